pipe_skid_buffer: RTL and testbench

- Two-entry elastic pipeline register placed between adjacent processor stages, for example IF/ID or ID/EX.
- It is the stall-aware consumer counterpart of the plain always-capture stage register.
- Upstream presents a word with a valid/ready handshake. Downstream reads it with its own valid/ready handshake.
- A stall is absorbed into a skid entry, so in_ready can be registered and no combinational ready path crosses stages.
- A synchronous flush squashes all held words on a branch or hazard redirect.

---
 rtl/pipe_skid_buffer_pkg.sv | 13 +
 rtl/pipe_skid_buffer_reg.sv | 23 ++
 rtl/pipe_skid_buffer.sv | 111 +++++++++++
 tb/tb_pipe_skid_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// Shared encodings for the two-entry skid pipeline register.
package pipe_skid_buffer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ONE     = 2'd1,
        ST_FULL    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_skid_buffer_reg.sv
// Generic N-bit register with load enable and async active-low clear.
module pipe_skid_buffer_reg #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_q <= '0;
        else if (i_en)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic stage register: main entry drives out_data, skid entry
// absorbs one word on stall so in_ready is a pure state decode.
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [OCC_W-1:0] occupancy
);

    state_e       r_state;
    state_e       w_next;
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic         w_main_en;
    logic         w_skid_en;
    logic [N-1:0] w_main_d;
    logic [N-1:0] w_main_q;
    logic [N-1:0] w_skid_q;

    assign w_in_xfer  = in_valid  && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer) w_next = ST_ONE;
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)
                        w_next = ST_FULL;
                    else if (!w_in_xfer && w_out_xfer)
                        w_next = ST_EMPTY;
                end
                ST_FULL:  if (w_out_xfer) w_next = ST_ONE;
                default:  w_next = ST_EMPTY;
            endcase
        end
    end

    // Outputs depend on r_state alone; the illegal code accepts nothing.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        occupancy = '0;
        case (r_state)
            ST_EMPTY: begin in_ready = 1'b1; end
            ST_ONE:   begin out_valid = 1'b1; in_ready = 1'b1; occupancy = 2'd1; end
            ST_FULL:  begin out_valid = 1'b1; occupancy = 2'd2; end
            default:  begin out_valid = 1'b0; end
        endcase
    end

    // Main reloads from skid when draining FULL, otherwise from the input.
    always_comb begin
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        w_main_d  = in_data;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_main_en = w_in_xfer;
                ST_ONE: begin
                    w_main_en = w_in_xfer && w_out_xfer;
                    w_skid_en = w_in_xfer && !w_out_xfer;
                end
                ST_FULL: begin
                    w_main_en = w_out_xfer;
                    w_main_d  = w_skid_q;
                end
                default: w_main_en = 1'b0;
            endcase
        end
    end

    pipe_skid_buffer_reg #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    pipe_skid_buffer_reg #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

    assign out_data = w_main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Scoreboard bench for pipe_skid_buffer: a queue model tracks accepted words.
module tb_pipe_skid_buffer;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] sb[$];

    pipe_skid_buffer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so at negedge they describe the next edge.
    always @(negedge clk) begin
        logic [N-1:0] exp;
        if (!reset) begin
            sb.delete();
        end else begin
            checks++;
            if (int'(occupancy) !== sb.size()) begin
                errors++;
                $display("FAIL mon_occupancy got %0d want %0d @%0t", occupancy, sb.size(), $time);
            end
            checks++;
            if (out_valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL mon_out_valid got %b want %b @%0t", out_valid, sb.size() != 0, $time);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected_out got %h want none @%0t", out_data, $time);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL mon_out_data got %h want %h @%0t", out_data, exp, $time);
                    end
                end
            end
            if (flush)
                sb.delete();
            else if (in_valid && in_ready)
                sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_full(input logic [N-1:0] a, input logic [N-1:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        tick();
        in_data   = b;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b occ=%0d d=%h want v=0 r=1 occ=0 d=0000",
                     out_valid, in_ready, occupancy, out_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = N'(i);
            tick();
            checks++;
            if (out_data !== N'(i) || out_valid !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_word%0d got d=%h v=%b occ=%0d r=%b want d=%h v=1 occ=1 r=1",
                         i, out_data, out_valid, occupancy, in_ready, N'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got occ=%0d want 0", occupancy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall_absorb();
        fill_full(16'hAAAA, 16'hBBBB);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hAAAA) begin
            errors++;
            $display("FAIL stall_full got occ=%0d r=%b d=%h want occ=2 r=0 d=aaaa", occupancy, in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 16'hBBBB || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL stall_second got d=%h occ=%0d want d=bbbb occ=1", out_data, occupancy);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_full(16'h1234, 16'h5678);
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h1234) begin
                errors++;
                $display("FAIL bp_hold%0d got occ=%0d r=%b d=%h want occ=2 r=0 d=1234",
                         i, occupancy, in_ready, out_data);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 16'h5678 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bp_release got d=%h r=%b occ=%0d want d=5678 r=1 occ=1", out_data, in_ready, occupancy);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_data !== 16'hCCCC || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL bp_accept got d=%h occ=%0d want d=cccc occ=1", out_data, occupancy);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        fill_full(16'h1111, 16'h2222);
        in_valid = 1'b1;
        in_data  = 16'h3333;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_empty got v=%b r=%b occ=%0d want v=0 r=1 occ=0", out_valid, in_ready, occupancy);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_noop got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_full(16'h4444, 16'h5555);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h occ=%0d r=%b want v=0 d=0000 occ=0 r=1",
                     out_valid, out_data, occupancy, in_ready);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_idle_read();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
                errors++;
                $display("FAIL idle%0d got v=%b occ=%0d want v=0 occ=0", i, out_valid, occupancy);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_absorb();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_idle_read();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained got %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
